calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 42 ++++
 rtl/calc_dec_accum.sv | 22 ++
 rtl/calc_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator key sequencer.
package calc_pkg;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        EXEC    = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        logic [1:0] op;
        case (k)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_dec_accum.sv
// Decimal digit accumulator: nxt = cur*10 + digit, holding cur when that
// would not fit in N bits.
module calc_dec_accum #(
    parameter int N = 8
) (
    input  logic [N-1:0] cur,
    input  logic [3:0]   digit,
    output logic [N-1:0] nxt
);

    // Four extra bits cover cur*10 + 9 for any cur below 2^N.
    logic [N+3:0] wide;

    always_comb begin
        wide = (N+4)'(cur) * (N+4)'(10) + (N+4)'(digit);
        if (wide[N+3:N] != 4'd0)
            nxt = cur;
        else
            nxt = wide[N-1:0];
    end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: collects two decimal operands and an operator,
// hands them to an external arithmetic unit and holds the result.
// Optional EXEC watchdog is enabled by defining CALC_TIMEOUT_EN.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int N   = 8,
    parameter int TMO = 255
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           key_valid,
    input  logic [3:0]     key_code,
    output logic           op_req,
    output logic [1:0]     op_code,
    output logic [N-1:0]   op_a,
    output logic [N-1:0]   op_b,
    input  logic           op_done,
    input  logic [2*N-1:0] op_result,
    input  logic           op_err,
    output logic [N-1:0]   entry,
    output logic [2*N-1:0] result,
    output logic           result_valid,
    output logic           err,
    output logic           busy
);

    if (TMO < 0) begin : g_tmo_chk
        $error("TMO must be non-negative");
    end

    state_t         state;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   acc_cur;
    logic [N-1:0]   acc_nxt;
    logic           result_fits;

    // One accumulator serves whichever operand is being keyed.
    assign acc_cur     = (state == ENTER_B) ? b : a;
    assign result_fits = !err && (result[2*N-1:N] == '0);

    calc_dec_accum #(.N(N)) u_accum (
        .cur   (acc_cur),
        .digit (key_code),
        .nxt   (acc_nxt)
    );

`ifdef CALC_TIMEOUT_EN
    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == CW'(TMO));
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state        <= ENTER_A;
            a            <= '0;
            b            <= '0;
            op_req       <= 1'b0;
            op_code      <= OP_ADD;
            op_a         <= '0;
            op_b         <= '0;
            entry        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else if (state == EXEC) begin
            // Keys are deliberately ignored here, even alongside op_done.
            if (op_done) begin
                result       <= op_result;
                err          <= op_err;
                op_req       <= 1'b0;
                result_valid <= 1'b1;
                busy         <= 1'b0;
                state        <= SHOW;
            end
`ifdef CALC_TIMEOUT_EN
            else if (tmo_hit) begin
                result       <= '0;
                err          <= 1'b1;
                op_req       <= 1'b0;
                result_valid <= 1'b1;
                busy         <= 1'b0;
                state        <= SHOW;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
        end else if (key_valid) begin
            if (key_code == KEY_CLR) begin
                a            <= '0;
                b            <= '0;
                entry        <= '0;
                result       <= '0;
                result_valid <= 1'b0;
                err          <= 1'b0;
                state        <= ENTER_A;
            end else begin
                case (state)
                    ENTER_A: begin
                        if (is_digit(key_code)) begin
                            a     <= acc_nxt;
                            entry <= acc_nxt;
                        end else if (is_op(key_code)) begin
                            op_code <= key_to_op(key_code);
                            b       <= '0;
                            entry   <= '0;
                            state   <= ENTER_B;
                        end else begin
                            result       <= {{N{1'b0}}, a};
                            err          <= 1'b0;
                            result_valid <= 1'b1;
                            state        <= SHOW;
                        end
                    end
                    ENTER_B: begin
                        if (is_digit(key_code)) begin
                            b     <= acc_nxt;
                            entry <= acc_nxt;
                        end else if (is_op(key_code)) begin
                            op_code <= key_to_op(key_code);
                        end else begin
                            op_req <= 1'b1;
                            op_a   <= a;
                            op_b   <= b;
                            busy   <= 1'b1;
                            state  <= EXEC;
`ifdef CALC_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end
                    end
                    SHOW: begin
                        if (is_digit(key_code)) begin
                            a            <= N'(key_code);
                            entry        <= N'(key_code);
                            result_valid <= 1'b0;
                            err          <= 1'b0;
                            state        <= ENTER_A;
                        end else if (is_op(key_code) && result_fits) begin
                            // Chain the previous result in as the next A.
                            a       <= result[N-1:0];
                            op_code <= key_to_op(key_code);
                            b       <= '0;
                            entry   <= '0;
                            state   <= ENTER_B;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
